bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the Mealy sequence detectors. Accepts WIDTH-bit words over a

---
 rtl/ser_pkg.sv | 19 +
 rtl/bit_serializer.sv | 136 +++++++++++++
 tb/tb_bit_serializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types for the bit serializer: FSM state encoding and counter width helper.
// S_PARITY keeps its encoding whether or not PARITY_EN is defined.
package ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } ser_state_t;

  localparam int SER_DEF_WIDTH = 8;

  function automatic int ser_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int SER_CNT_W = ser_cnt_w(SER_DEF_WIDTH);

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with valid/ready input and registered serial output.
// Optional even-parity bit after each word when PARITY_EN is defined.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy
);
  import ser_pkg::*;

  localparam int CW = ser_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             vld_q, vld_d;
  logic             accept;
  logic             last;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last   = (state_q == S_SHIFT) && (cnt_q == '0);
  assign accept = in_valid && in_ready;

`ifdef PARITY_EN
  assign in_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
`else
  assign in_ready = (state_q == S_IDLE) || last;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
`ifdef PARITY_EN
          state_d = S_PARITY;
`else
          state_d = accept ? S_SHIFT : S_IDLE;
`endif
        end
      end
      S_PARITY: begin
`ifdef PARITY_EN
        state_d = accept ? S_SHIFT : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next serial bit is precomputed so ser_bit/ser_valid come straight from flops.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bit_d   = IDLE_BIT;
    vld_d   = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      shreg_d = shift(in_data);
      cnt_d   = CNT_LOAD;
      bit_d   = first_bit(in_data);
      vld_d   = 1'b1;
`ifdef PARITY_EN
      par_d   = ^in_data;
`endif
    end else if (state_q == S_SHIFT && cnt_q != '0) begin
      shreg_d = shift(shreg_q);
      cnt_d   = cnt_q - 1'b1;
      bit_d   = first_bit(shreg_q);
      vld_d   = 1'b1;
    end
`ifdef PARITY_EN
    else if (last) begin
      bit_d = par_q;
      vld_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      bit_q   <= IDLE_BIT;
      vld_q   <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ser_bit   = bit_q;
  assign ser_valid = vld_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances.
// Expectations follow PARITY_EN when it is defined for the build.
module tb_bit_serializer;

`ifdef PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dm, dl;
  logic       vm, vl;
  logic       rm, rl;
  logic       bm, bl;
  logic       sm, sl;
  logic       ym, yl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(dm), .in_valid(vm),
    .in_ready(rm), .ser_bit(bm), .ser_valid(sm), .busy(ym)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(dl), .in_valid(vl),
    .in_ready(rl), .ser_bit(bl), .ser_valid(sl), .busy(yl)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // seq lists the data bits in emission order, first bit at seq[7].
  task automatic run_word(input string tag, input bit lsb,
                          input logic [7:0] w, input logic [7:0] seq,
                          input logic par, output logic [8:0] hits);
    logic [3:0] hist;
    logic       e, ob;
    hist = '0;
    hits = '0;
    check({tag, "_rdy_idle"}, lsb ? rl : rm, 1);
    if (lsb) begin vl = 1; dl = w; end
    else     begin vm = 1; dm = w; end
    @(negedge clk);
    vl = 0; vm = 0; dl = ~w; dm = ~w;
    for (int k = 0; k < NB; k++) begin
      e  = (k < 8) ? seq[7-k] : par;
      ob = lsb ? bl : bm;
      check($sformatf("%s_bit%0d", tag, k), ob, e);
      check($sformatf("%s_vld%0d", tag, k), lsb ? sl : sm, 1);
      check($sformatf("%s_rdy%0d", tag, k), lsb ? rl : rm, k == NB - 1);
      check($sformatf("%s_busy%0d", tag, k), lsb ? yl : ym, 1);
      hist = {hist[2:0], ob};
      if (hist == 4'b1001) hits[k] = 1'b1;
      @(negedge clk);
    end
    check({tag, "_end_vld"}, lsb ? sl : sm, 0);
    check({tag, "_end_bit"}, lsb ? bl : bm, 0);
    check({tag, "_end_busy"}, lsb ? yl : ym, 0);
  endtask

  initial begin
    logic [8:0]  hits;
    logic [7:0]  seq;
    logic        e;
    int          i, j;
    reset = 1; vm = 1; dm = 8'hFF; vl = 1; dl = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_vld_m", sm, 0);
    check("rst_bit_m", bm, 0);
    check("rst_busy_m", ym, 0);
    check("rst_rdy_m", rm, 1);
    check("rst_vld_l", sl, 0);
    check("rst_rdy_l", rl, 1);
    reset = 0; vm = 0; vl = 0;
    @(negedge clk);
    check("post_rst_vld", sm, 0);
    check("post_rst_busy", ym, 0);

    // single word, with 1001 detection positions
    run_word("w99", 0, 8'h99, 8'b10011001, 1'b0, hits);
    check("det1001", hits, 9'h088);

    // back-to-back plus data wiggling while in_ready is low
    vm = 1; dm = 8'hF0;
    @(negedge clk);
    dm = 8'h3C;
    for (int k = 1; k <= 2 * NB; k++) begin
      i   = (k - 1) / NB;
      j   = (k - 1) % NB;
      seq = (i == 0) ? 8'b11110000 : 8'b00001111;
      e   = (j < 8) ? seq[7-j] : 1'b0;
      check($sformatf("b2b_bit%0d", k), bm, e);
      check($sformatf("b2b_vld%0d", k), sm, 1);
      check($sformatf("b2b_rdy%0d", k), rm, (k == NB) || (k == 2 * NB));
      if (k < NB - 1) dm = 8'(8'h3C ^ k);
      if (k == NB - 1) dm = 8'h0F;
      if (k == NB + 1) begin vm = 0; dm = 8'hAA; end
      @(negedge clk);
    end
    check("b2b_end_vld", sm, 0);
    check("b2b_end_busy", ym, 0);

    run_word("l01", 1, 8'h01, 8'b10000000, 1'b1, hits);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_vld%0d", k), sl, 0);
      check($sformatf("stall_bit%0d", k), bl, 0);
      @(negedge clk);
    end

    run_word("p07", 0, 8'h07, 8'b00000111, 1'b1, hits);
    run_word("p03", 0, 8'h03, 8'b00000011, 1'b0, hits);

    // reset three bits into 8'hA5
    vm = 1; dm = 8'hA5;
    @(negedge clk);
    vm = 0;
    check("a5_bit0", bm, 1);
    @(negedge clk);
    check("a5_bit1", bm, 0);
    @(negedge clk);
    check("a5_bit2", bm, 1);
    reset = 1; vm = 1; dm = 8'hFF;
    @(negedge clk);
    check("mid_rst_vld", sm, 0);
    check("mid_rst_bit", bm, 0);
    check("mid_rst_busy", ym, 0);
    check("mid_rst_rdy", rm, 1);
    reset = 0; vm = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("abort_vld%0d", k), sm, 0);
      check($sformatf("abort_bit%0d", k), bm, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
